// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX
  } state_e;

  localparam int N_ITER = 32;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negator, used both for operand magnitudes
// and for the final sign fix of products, quotients and remainders.
module mdu_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_en_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_en_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers:
// shift-add multiply or restoring divide on magnitudes, then one sign-fix cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opA_q, opA_d, opB_q, opB_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 signLo_q, signLo_d, signHi_q, signHi_d;
  logic                 done_q, done_d;

  op_e                  opIn;
  logic                 inSigned, inDiv, aNeg, bNeg, isDiv;
  logic [WIDTH-1:0]     absA, absB, quoFix, remFix;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH:0]       mulSum, remShift;
  logic                 trialNeg;
  logic [WIDTH-1:0]     trialDiff;

  assign opIn     = op_e'(op_i);
  assign inSigned = (opIn == OP_MULT) || (opIn == OP_DIV);
  assign inDiv    = (opIn == OP_DIV) || (opIn == OP_DIVU);
  assign aNeg     = inSigned & a_i[WIDTH-1];
  assign bNeg     = inSigned & b_i[WIDTH-1];
  assign isDiv    = (op_q == OP_DIV) || (op_q == OP_DIVU);

  mdu_abs_neg #(.WIDTH(WIDTH)) uAbsA (.in_i(a_i), .neg_en_i(aNeg), .out_o(absA));
  mdu_abs_neg #(.WIDTH(WIDTH)) uAbsB (.in_i(b_i), .neg_en_i(bNeg), .out_o(absB));

  mdu_abs_neg #(.WIDTH(2*WIDTH)) uProdFix (
    .in_i(acc_q), .neg_en_i(signLo_q), .out_o(prodFix));
  mdu_abs_neg #(.WIDTH(WIDTH)) uQuoFix (
    .in_i(acc_q[WIDTH-1:0]), .neg_en_i(signLo_q), .out_o(quoFix));
  mdu_abs_neg #(.WIDTH(WIDTH)) uRemFix (
    .in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_en_i(signHi_q), .out_o(remFix));

  // Remainder can briefly need WIDTH+1 bits after the shift, before the trial subtract.
  assign mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opB_q[0] ? {1'b0, opA_q} : '0);
  assign remShift  = acc_q[2*WIDTH-1:WIDTH-1];
  assign trialNeg  = remShift < {1'b0, opB_q};
  assign trialDiff = remShift[WIDTH-1:0] - opB_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    signLo_d = signLo_q;
    signHi_d = signHi_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          op_d     = opIn;
          opA_d    = absA;
          opB_d    = absB;
          acc_d    = inDiv ? {{WIDTH{1'b0}}, absA} : '0;
          cnt_d    = '0;
          // Divide by zero keeps the all-ones quotient unsigned.
          signLo_d = (aNeg ^ bNeg) && !(inDiv && (b_i == '0));
          signHi_d = aNeg;
          state_d  = ST_ITER;
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (isDiv) begin
          if (!trialNeg) acc_d = {trialDiff, acc_q[WIDTH-2:0], 1'b1};
          else           acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
          opB_d = opB_q >> 1;
        end
        if (cnt_q == CNT_W'(N_ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (isDiv) begin
          lo_d = quoFix;
          hi_d = remFix;
        end else begin
          {hi_d, lo_d} = prodFix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      signLo_q <= 1'b0;
      signHi_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      signLo_q <= signLo_d;
      signHi_q <= signHi_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, wdata_i;
  logic        hi_we_i, lo_we_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results {hi, lo} straight from MIPS semantics.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint p;
    int     sq, sr;
    case (op)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
      end
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo);
    int waited, busyCnt;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
    waited = 0; busyCnt = 0;
    while (done_o !== 1'b1 && waited < 60) begin
      if (busy_o === 1'b1) busyCnt++;
      tick();
      waited++;
    end
    checkOutput({tag, " done"}, {31'b0, done_o}, 32'd1);
    checkOutput({tag, " latency"}, 32'(waited), 32'd33);
    checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'd33);
    checkOutput({tag, " hi"}, hi_o, expHi);
    checkOutput({tag, " lo"}, lo_o, expLo);
    checkOutput({tag, " busy after"}, {31'b0, busy_o}, 32'd0);
    tick();
    checkOutput({tag, " done pulse width"}, {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    int          waited, doneCnt, busyCnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] model;

    reset = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    tick(); tick();
    checkOutput("reset hi", hi_o, 32'h0);
    checkOutput("reset lo", lo_o, 32'h0);
    checkOutput("reset busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset done", {31'b0, done_o}, 32'd0);
    reset = 1'b1;
    tick();

    applyStimulus("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    applyStimulus("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    applyStimulus("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    applyStimulus("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    applyStimulus("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    applyStimulus("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Second start and mthi at T10 must both be ignored.
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd5;
    hi_we_i = 1'b1; wdata_i = 32'h1234;
    tick();
    start_i = 1'b0; hi_we_i = 1'b0;
    waited = 10;
    while (done_o !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    checkOutput("restart latency", 32'(waited), 32'd33);
    checkOutput("restart hi", hi_o, 32'd2);
    checkOutput("restart lo", lo_o, 32'd14);
    doneCnt = 0; busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o === 1'b1) doneCnt++;
      if (busy_o === 1'b1) busyCnt++;
    end
    checkOutput("restart extra done", 32'(doneCnt), 32'd0);
    checkOutput("restart no queue", 32'(busyCnt), 32'd0);

    hi_we_i = 1'b1; wdata_i = 32'h1234;
    tick();
    hi_we_i = 1'b0;
    checkOutput("mthi hi", hi_o, 32'h1234);
    checkOutput("mthi lo kept", lo_o, 32'd14);
    lo_we_i = 1'b1; wdata_i = 32'hCAFE;
    tick();
    lo_we_i = 1'b0;
    checkOutput("mtlo lo", lo_o, 32'hCAFE);
    checkOutput("mtlo hi kept", hi_o, 32'h1234);

    // Reset at T15 of a DIV aborts it silently.
    start_i = 1'b1; op_i = OP_DIV; a_i = 32'hFFFF_FFF9; b_i = 32'd2;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    reset = 1'b0;
    tick();
    checkOutput("abort hi", hi_o, 32'h0);
    checkOutput("abort lo", lo_o, 32'h0);
    checkOutput("abort busy", {31'b0, busy_o}, 32'd0);
    checkOutput("abort done", {31'b0, done_o}, 32'd0);
    reset = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o === 1'b1) doneCnt++;
    end
    checkOutput("abort no done", 32'(doneCnt), 32'd0);
    applyStimulus("after abort", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom);
      ra    = pickOperand();
      rb    = pickOperand();
      model = refModel(rop, ra, rb);
      applyStimulus($sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb,
                    model[63:32], model[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
